// File: rtl/reg_writeback_if.sv
// Signal bundle between the register-file write front end and its producers/consumers.
// slave = the writeback block, master = the pipeline/long-unit/issue side.
interface reg_writeback_if #(
  parameter int FIFO_AW = 2
);
  logic               alu_wr;
  logic [4:0]         alu_rd;
  logic [31:0]        alu_data;
  logic               lng_issue;
  logic [4:0]         lng_issue_rd;
  logic               lng_valid;
  logic               lng_ready;
  logic [4:0]         lng_rd;
  logic [31:0]        lng_data;
  logic               regwrite;
  logic [4:0]         regtowrite;
  logic [31:0]        datatowrite;
  logic [31:0]        busy;
  logic [FIFO_AW:0]   fifo_count;
  logic               hazard_err;

  modport master (
    output alu_wr, alu_rd, alu_data,
    output lng_issue, lng_issue_rd,
    output lng_valid, lng_rd, lng_data,
    input  lng_ready,
    input  regwrite, regtowrite, datatowrite,
    input  busy, fifo_count, hazard_err
  );

  modport slave (
    input  alu_wr, alu_rd, alu_data,
    input  lng_issue, lng_issue_rd,
    input  lng_valid, lng_rd, lng_data,
    output lng_ready,
    output regwrite, regtowrite, datatowrite,
    output busy, fifo_count, hazard_err
  );
endinterface

// File: rtl/reg_writeback.sv
// Register-file write front end: merges ALU writeback with FIFO-buffered long-latency
// results into one registered write slot, and tracks pending long results per register.
module reg_writeback #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  reg_writeback_if.slave  bus
);

  logic [4:0]         r_fifo_rd   [FIFO_DEPTH];
  logic [31:0]        r_fifo_data [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_count;
  logic [31:0]        r_busy;
  logic               r_err;
  logic               r_wr_p1;
  logic [4:0]         r_rd_p1;
  logic [31:0]        r_data_p1;

  logic               w_ready;
  logic               w_push;
  logic               w_pop;
  logic [4:0]         w_head_rd;
  logic [31:0]        w_head_data;
  logic               w_slot_vld;
  logic [4:0]         w_slot_rd;
  logic [31:0]        w_slot_data;
  logic [31:0]        w_busy_set;
  logic [31:0]        w_busy_clr;
  logic [31:0]        w_busy_nxt;
  logic               w_hazard;

  assign w_ready     = (r_count < (FIFO_AW+1)'(FIFO_DEPTH));
  assign w_push      = bus.lng_valid & w_ready;
  // ALU writeback always owns the slot; the FIFO only drains on idle ALU cycles.
  assign w_pop       = ~bus.alu_wr & (r_count != '0);
  assign w_head_rd   = r_fifo_rd[r_rptr];
  assign w_head_data = r_fifo_data[r_rptr];

  assign w_slot_vld  = bus.alu_wr | w_pop;
  assign w_slot_rd   = bus.alu_wr ? bus.alu_rd   : w_head_rd;
  assign w_slot_data = bus.alu_wr ? bus.alu_data : w_head_data;

  // Set is applied after clear so a newly issued op to the same register keeps it busy.
  assign w_busy_clr  = (w_pop && (w_head_rd != 5'd0)) ? (32'd1 << w_head_rd) : 32'd0;
  assign w_busy_set  = (bus.lng_issue && (bus.lng_issue_rd != 5'd0)) ?
                       (32'd1 << bus.lng_issue_rd) : 32'd0;
  assign w_busy_nxt  = (r_busy & ~w_busy_clr) | w_busy_set;

  assign w_hazard    = (bus.lng_issue && r_busy[bus.lng_issue_rd])
                     | (bus.alu_wr && r_busy[bus.alu_rd])
                     | (w_pop && (w_head_rd != 5'd0) && !r_busy[w_head_rd]);

  // ---- stage p0: FIFO storage (data only, no reset needed) ----
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= bus.lng_rd;
      r_fifo_data[r_wptr] <= bus.lng_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_busy  <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_busy <= w_busy_nxt;
      if (w_hazard) r_err <= 1'b1;
    end
  end

  // ---- stage p1: registered write slot toward the register file ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_p1   <= 1'b0;
      r_rd_p1   <= 5'd0;
      r_data_p1 <= 32'd0;
    end else if (w_slot_vld) begin
      r_wr_p1   <= (w_slot_rd != 5'd0);
      r_rd_p1   <= w_slot_rd;
      r_data_p1 <= w_slot_data;
    end else begin
      r_wr_p1   <= 1'b0;
    end
  end

  assign bus.lng_ready   = w_ready;
  assign bus.regwrite    = r_wr_p1;
  assign bus.regtowrite  = r_rd_p1;
  assign bus.datatowrite = r_data_p1;
  assign bus.busy        = r_busy;
  assign bus.fifo_count  = r_count;
  assign bus.hazard_err  = r_err;

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenarios plus constrained-random traffic,
// all checked against a queue-based reference model of the writeback rules.
module tb_reg_writeback;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  reg_writeback_if #(.FIFO_AW(AW)) bus ();
  reg_writeback #(.FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  ent_t        q[$];
  ent_t        dq[$];
  logic [31:0] m_busy;
  bit          m_err;
  bit          m_wr;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_pushed;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.alu_wr = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.lng_issue = 0; bus.lng_issue_rd = 0;
    bus.lng_valid = 0; bus.lng_rd = 0; bus.lng_data = 0;
  endtask

  task automatic model_reset();
    q.delete();
    m_busy = 0; m_err = 0; m_wr = 0; m_rd = 0; m_data = 0; m_pushed = 0;
  endtask

  // One clock edge of the writeback rules, using the inputs present at that edge.
  task automatic model_step();
    ent_t e;
    bit   ready;
    ready    = (q.size() < DEPTH);
    m_pushed = bus.lng_valid && ready;
    if (bus.lng_issue && m_busy[bus.lng_issue_rd]) m_err = 1;
    if (bus.alu_wr) begin
      if (m_busy[bus.alu_rd]) m_err = 1;
      m_wr = (bus.alu_rd != 0); m_rd = bus.alu_rd; m_data = bus.alu_data;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      if (e.rd != 0 && !m_busy[e.rd]) m_err = 1;
      m_wr = (e.rd != 0); m_rd = e.rd; m_data = e.data;
      if (e.rd != 0) m_busy[e.rd] = 0;
    end else begin
      m_wr = 0;
    end
    if (bus.lng_issue && bus.lng_issue_rd != 0) m_busy[bus.lng_issue_rd] = 1;
    if (m_pushed) q.push_back('{bus.lng_rd, bus.lng_data});
  endtask

  task automatic compare_all(input string t);
    chk({t, "_regwrite"}, 64'(bus.regwrite), 64'(m_wr));
    if (m_wr) begin
      chk({t, "_regtowrite"}, 64'(bus.regtowrite), 64'(m_rd));
      chk({t, "_datatowrite"}, 64'(bus.datatowrite), 64'(m_data));
    end
    chk({t, "_busy"}, 64'(bus.busy), 64'(m_busy));
    chk({t, "_count"}, 64'(bus.fifo_count), 64'(q.size()));
    chk({t, "_ready"}, 64'(bus.lng_ready), 64'(q.size() < DEPTH));
    chk({t, "_hazard"}, 64'(bus.hazard_err), 64'(m_err));
  endtask

  task automatic tick(input string t);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all(t);
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1;
    compare_all("reset");
    chk("reset_regwrite0", 64'(bus.regwrite), 64'd0);
    chk("reset_ready1", 64'(bus.lng_ready), 64'd1);
  endtask

  initial begin
    bit holding;
    int n;
    logic [4:0] r;
    idle();
    reset_n = 0;
    model_reset();
    do_reset();

    // Scenario 1: single ALU write, then idle
    bus.alu_wr = 1; bus.alu_rd = 5; bus.alu_data = 32'h12345678;
    tick("t1a");
    chk("t1_wr", 64'(bus.regwrite), 64'd1);
    chk("t1_rd", 64'(bus.regtowrite), 64'd5);
    chk("t1_data", 64'(bus.datatowrite), 64'h12345678);
    idle();
    tick("t1b");
    chk("t1_idle", 64'(bus.regwrite), 64'd0);

    // Scenario 2: long op issue, result, pop
    bus.lng_issue = 1; bus.lng_issue_rd = 9;
    tick("t2a");
    idle();
    chk("t2_busy_set", 64'(bus.busy[9]), 64'd1);
    tick("t2b"); tick("t2c");
    bus.lng_valid = 1; bus.lng_rd = 9; bus.lng_data = 32'hCAFEF00D;
    tick("t2push");
    idle();
    chk("t2_busy_held", 64'(bus.busy[9]), 64'd1);
    chk("t2_nowrite_yet", 64'(bus.regwrite), 64'd0);
    tick("t2pop");
    chk("t2_wr", 64'(bus.regwrite), 64'd1);
    chk("t2_data", 64'(bus.datatowrite), 64'hCAFEF00D);
    chk("t2_busy_clr", 64'(bus.busy[9]), 64'd0);

    // Scenario 3: two buffered results wait behind an ALU stream
    bus.lng_issue = 1; bus.lng_issue_rd = 3;
    tick("t3a");
    bus.lng_issue_rd = 4; bus.lng_valid = 1; bus.lng_rd = 3; bus.lng_data = 32'h33;
    bus.alu_wr = 1; bus.alu_rd = 20; bus.alu_data = 32'h20;
    tick("t3b");
    bus.lng_issue = 0; bus.lng_rd = 4; bus.lng_data = 32'h44; bus.alu_rd = 21;
    tick("t3c");
    bus.lng_valid = 0;
    chk("t3_count2", 64'(bus.fifo_count), 64'd2);
    for (int i = 0; i < 3; i++) begin
      bus.alu_rd = 5'(22 + i); bus.alu_data = $urandom;
      tick("t3alu");
      chk("t3_alu_hold", 64'(bus.fifo_count), 64'd2);
    end
    idle();
    tick("t3d");
    chk("t3_first_rd3", 64'(bus.regtowrite), 64'd3);
    chk("t3_count1", 64'(bus.fifo_count), 64'd1);
    tick("t3e");
    chk("t3_second_rd4", 64'(bus.regtowrite), 64'd4);
    chk("t3_count0", 64'(bus.fifo_count), 64'd0);

    // Scenario 4: fill FIFO, back-pressure, drain
    for (int i = 0; i < 5; i++) begin
      bus.lng_issue = 1; bus.lng_issue_rd = 5'(10 + i);
      tick("t4iss");
    end
    idle();
    bus.alu_wr = 1; bus.alu_rd = 25;
    for (int i = 0; i < 4; i++) begin
      bus.lng_valid = 1; bus.lng_rd = 5'(10 + i); bus.lng_data = $urandom;
      tick("t4fill");
    end
    chk("t4_full_count", 64'(bus.fifo_count), 64'd4);
    chk("t4_not_ready", 64'(bus.lng_ready), 64'd0);
    bus.lng_rd = 14; bus.lng_data = 32'h14141414;
    tick("t4blocked");
    chk("t4_no_push_full", 64'(bus.fifo_count), 64'd4);
    bus.alu_wr = 0;
    tick("t4pop1");
    chk("t4_ready_after_pop", 64'(bus.lng_ready), 64'd1);
    tick("t4push5");
    bus.lng_valid = 0;
    n = 0;
    while (bus.fifo_count != 0 && n < 20) begin
      tick("t4drain");
      n++;
    end
    chk("t4_drained", 64'(bus.fifo_count), 64'd0);

    // Scenario 5: writes to $zero
    bus.alu_wr = 1; bus.alu_rd = 0; bus.alu_data = 32'hDEAD;
    tick("t5a");
    chk("t5_alu_zero", 64'(bus.regwrite), 64'd0);
    idle();
    bus.lng_valid = 1; bus.lng_rd = 0; bus.lng_data = 32'hBEEF;
    tick("t5b");
    idle();
    tick("t5c");
    chk("t5_lng_zero", 64'(bus.regwrite), 64'd0);
    chk("t5_consumed", 64'(bus.fifo_count), 64'd0);
    chk("t5_no_hazard", 64'(bus.hazard_err), 64'd0);

    // Scenario 6: WAW hazard, then reset in the middle of draining
    bus.lng_issue = 1; bus.lng_issue_rd = 7;
    tick("t6a");
    tick("t6b");
    chk("t6_waw", 64'(bus.hazard_err), 64'd1);
    idle();
    bus.alu_wr = 1; bus.alu_rd = 26;
    bus.lng_valid = 1; bus.lng_rd = 7; bus.lng_data = 32'h71;
    tick("t6c");
    bus.lng_data = 32'h72;
    tick("t6d");
    idle();
    tick("t6e");
    chk("t6_sticky", 64'(bus.hazard_err), 64'd1);
    #2 reset_n = 0;
    #1;
    model_reset();
    chk("t6_rst_busy", 64'(bus.busy), 64'd0);
    chk("t6_rst_count", 64'(bus.fifo_count), 64'd0);
    chk("t6_rst_wr", 64'(bus.regwrite), 64'd0);
    chk("t6_rst_err", 64'(bus.hazard_err), 64'd0);
    @(negedge clk);
    reset_n = 1;
    tick("t6f");
    chk("t6_no_write_after", 64'(bus.regwrite), 64'd0);

    // Constrained-random traffic that never violates the protocol
    do_reset();
    dq.delete();
    holding = 0;
    for (int c = 0; c < 600; c++) begin
      if (!holding) begin
        if (dq.size() > 0 && ($urandom % 2 == 1)) begin
          bus.lng_valid = 1; bus.lng_rd = dq[0].rd; bus.lng_data = dq[0].data;
        end else begin
          bus.lng_valid = 0;
        end
      end
      r = 5'($urandom_range(1, 31));
      if ($urandom % 3 == 0 && !m_busy[r]) begin
        bus.lng_issue = 1; bus.lng_issue_rd = r;
        dq.push_back('{r, $urandom});
      end else begin
        bus.lng_issue = 0; bus.lng_issue_rd = 5'($urandom);
      end
      bus.alu_wr   = ($urandom % 2 == 1);
      bus.alu_rd   = 5'($urandom_range(0, 31));
      if (m_busy[bus.alu_rd]) bus.alu_rd = 0;
      bus.alu_data = $urandom;
      tick("rnd");
      if (bus.lng_valid && m_pushed) begin
        void'(dq.pop_front());
        holding = 0;
      end else begin
        holding = bus.lng_valid;
      end
    end
    idle();
    n = 0;
    while (bus.fifo_count != 0 && n < 20) begin
      tick("rnd_drain");
      n++;
    end
    chk("rnd_drained", 64'(bus.fifo_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
